i2c_slave_regmap: RTL and testbench

Byte-level register-map back end placed directly downstream of the i2c_slave bit engine. It consumes received-byte strobes and bus-condition flags. It implements the standard pointer-then-data protocol over an internal register array with auto-incrementing address. It returns transmit bytes to the bit engine on request, and gives local logic a host read/write port plus write-event notification.

---
 rtl/i2c_slave_regmap.sv | 168 ++++++++++++++++
 tb/tb_i2c_slave_regmap.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regmap.sv
// i2c_slave_regmap
//   Byte-level register-map back end for the i2c_slave bit engine.
//   The first data byte of a write transaction loads the register pointer.
//   Later bytes write regs[ptr]. Each transmit request returns regs[ptr].
//   The pointer auto-increments after every access and wraps at 2**ADDR_W.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid     master-written data byte and its 1-cycle strobe
//   tx_req                bit engine requests the next read byte
//   start_pulse           1-cycle START
//   restart_pulse         1-cycle repeated START
//   stop_pulse            1-cycle STOP
//   tx_data, tx_load      byte to transmit, 1-cycle load strobe
//   host_we, host_addr,   local host write port
//   host_wdata
//   host_rdata            registered read of regs[host_addr]
//   reg_wr_evt,           1-cycle notification of an I2C register write
//   reg_wr_addr
//   ptr                   current register pointer
//   busy                  high from START until STOP
module i2c_slave_regmap #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_req,
    input  logic              start_pulse,
    input  logic              restart_pulse,
    input  logic              stop_pulse,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              reg_wr_evt,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PTR   = 2'd1,
        ST_WDATA = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_regs [DEPTH];
    logic [ADDR_W-1:0]  r_ptr;
    logic [7:0]         r_tx_data;
    logic               r_tx_load;
    logic [7:0]         r_host_rdata;
    logic               r_wr_evt;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_busy;

    logic               w_do_ptr;
    logic               w_do_wr;
    logic               w_do_rd;

    // The data action is decoded from the current state. Bus conditions
    // only choose the next state: stop beats start/restart, and both beat
    // the data transition. A receive strobe takes precedence over a
    // transmit request in the same cycle.
    always_comb begin
        w_next   = r_state;
        w_do_ptr = 1'b0;
        w_do_wr  = 1'b0;
        w_do_rd  = 1'b0;
        case (r_state)
            ST_PTR: begin
                if (rx_valid) begin
                    w_do_ptr = 1'b1;
                    w_next   = ST_WDATA;
                end else if (tx_req) begin
                    w_do_rd = 1'b1;
                    w_next  = ST_READ;
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    w_do_wr = 1'b1;
                end else if (tx_req) begin
                    w_do_rd = 1'b1;
                    w_next  = ST_READ;
                end
            end
            ST_READ: begin
                if (tx_req) begin
                    w_do_rd = 1'b1;
                end
            end
            default: ;
        endcase

        if (stop_pulse) begin
            w_next = ST_IDLE;
        end else if (start_pulse || (restart_pulse && r_state != ST_IDLE)) begin
            w_next = ST_PTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_ptr        <= '0;
            r_tx_data    <= 8'hff;
            r_tx_load    <= 1'b0;
            r_host_rdata <= RESET_VAL;
            r_wr_evt     <= 1'b0;
            r_wr_addr    <= '0;
        end else begin
            r_host_rdata <= r_regs[host_addr];
            r_tx_load    <= w_do_rd;
            r_wr_evt     <= w_do_wr;

            // The I2C write comes after the host write, so it overrides a
            // host write to the same index in the same cycle.
            if (host_we) begin
                r_regs[host_addr] <= host_wdata;
            end
            if (w_do_wr) begin
                r_regs[r_ptr] <= rx_data;
                r_wr_addr     <= r_ptr;
            end

            if (w_do_rd) begin
                r_tx_data <= r_regs[r_ptr];
            end

            if (w_do_ptr) begin
                r_ptr <= rx_data[ADDR_W-1:0];
            end else if (w_do_wr || w_do_rd) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_load     = r_tx_load;
    assign host_rdata  = r_host_rdata;
    assign reg_wr_evt  = r_wr_evt;
    assign reg_wr_addr = r_wr_addr;
    assign ptr         = r_ptr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// tb_i2c_slave_regmap
//   Directed stimulus with a queue-based scoreboard for tx_load and
//   reg_wr_evt, plus direct checks of host reads, ptr and busy.
module tb_i2c_slave_regmap;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       start_pulse;
    logic       restart_pulse;
    logic       stop_pulse;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       reg_wr_evt;
    logic [3:0] reg_wr_addr;
    logic [3:0] ptr;
    logic       busy;

    i2c_slave_regmap #(.ADDR_W(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req),
        .start_pulse(start_pulse), .restart_pulse(restart_pulse),
        .stop_pulse(stop_pulse),
        .tx_data(tx_data), .tx_load(tx_load),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .reg_wr_evt(reg_wr_evt), .reg_wr_addr(reg_wr_addr),
        .ptr(ptr), .busy(busy)
    );

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t txq[$];
    exp_t wq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: every tx_load / reg_wr_evt must match the head of its queue,
    // including the cycle in which it appears.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (tx_load) begin
                checks++;
                if (txq.size() == 0) begin
                    failures++;
                    $display("FAIL tx_load_unexpected got=%h cyc=%0d", tx_data, cyc);
                end else begin
                    e = txq.pop_front();
                    if (tx_data !== e.d || cyc != e.c) begin
                        failures++;
                        $display("FAIL tx_data got=%h@%0d exp=%h@%0d", tx_data, cyc, e.d, e.c);
                    end
                end
            end
            if (reg_wr_evt) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL wr_evt_unexpected got=%h cyc=%0d", reg_wr_addr, cyc);
                end else begin
                    e = wq.pop_front();
                    if ({4'h0, reg_wr_addr} !== e.d || cyc != e.c) begin
                        failures++;
                        $display("FAIL wr_evt got=%h@%0d exp=%h@%0d", reg_wr_addr, cyc, e.d, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [3:0] a);
        exp_t e;
        e.d = {4'h0, a};
        e.c = cyc + 1;
        wq.push_back(e);
    endtask

    task automatic rx(input logic [7:0] d, input bit expect_wr, input logic [3:0] a);
        @(negedge clk);
        rx_data  = d;
        rx_valid = 1'b1;
        if (expect_wr) push_wr(a);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic treq(input bit expect_ld, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        tx_req = 1'b1;
        if (expect_ld) begin
            e.d = d;
            e.c = cyc + 1;
            txq.push_back(e);
        end
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    task automatic cond(input int which);
        @(negedge clk);
        case (which)
            0: start_pulse   = 1'b1;
            1: restart_pulse = 1'b1;
            default: stop_pulse = 1'b1;
        endcase
        @(negedge clk);
        start_pulse   = 1'b0;
        restart_pulse = 1'b0;
        stop_pulse    = 1'b0;
    endtask

    task automatic hread(input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        host_we   = 1'b0;
        host_addr = a;
        @(negedge clk);
        chk($sformatf("host_rdata[%0d]", a), {24'h0, host_rdata}, {24'h0, exp});
    endtask

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_req = 1'b0;
        start_pulse = 1'b0; restart_pulse = 1'b0; stop_pulse = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #23;
        chk("rst_ptr", {28'h0, ptr}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'hff);
        chk("rst_tx_load", {31'h0, tx_load}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) hread(4'(i), 8'h00);

        // Pointer then two data bytes
        cond(0);
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        rx(8'h03, 1'b0, 4'h0);
        rx(8'hA5, 1'b1, 4'h3);
        rx(8'h5A, 1'b1, 4'h4);
        cond(2);
        chk("busy_after_stop", {31'h0, busy}, 32'h0);
        chk("ptr_after_wr", {28'h0, ptr}, 32'h5);
        hread(4'h3, 8'hA5);
        hread(4'h4, 8'h5A);

        // Pointer wrap, upper pointer bits masked
        cond(0);
        rx(8'h0F, 1'b0, 4'h0);
        rx(8'h11, 1'b1, 4'hF);
        rx(8'h22, 1'b1, 4'h0);
        chk("ptr_wrap", {28'h0, ptr}, 32'h1);
        cond(2);
        hread(4'hF, 8'h11);
        hread(4'h0, 8'h22);
        cond(0);
        rx(8'hF2, 1'b0, 4'h0);
        chk("ptr_masked", {28'h0, ptr}, 32'h2);
        cond(2);

        // Combined write-pointer / repeated-start read
        cond(0);
        rx(8'h03, 1'b0, 4'h0);
        cond(1);
        chk("busy_restart", {31'h0, busy}, 32'h1);
        treq(1'b1, 8'hA5);
        treq(1'b1, 8'h5A);
        chk("ptr_after_read", {28'h0, ptr}, 32'h5);
        rx(8'h99, 1'b0, 4'h0);  // ignored in READ
        chk("ptr_read_rx_ignored", {28'h0, ptr}, 32'h5);
        cond(2);

        // Same-index host/I2C write collision: I2C wins
        cond(0);
        rx(8'h07, 1'b0, 4'h0);
        @(negedge clk);
        rx_data = 8'h77; rx_valid = 1'b1;
        host_we = 1'b1; host_addr = 4'h7; host_wdata = 8'hEE;
        push_wr(4'h7);
        @(negedge clk);
        rx_valid = 1'b0; host_we = 1'b0;
        hread(4'h7, 8'h77);
        cond(2);
        // Different indices: both complete
        cond(0);
        rx(8'h07, 1'b0, 4'h0);
        @(negedge clk);
        rx_data = 8'h01; rx_valid = 1'b1;
        host_we = 1'b1; host_addr = 4'h8; host_wdata = 8'hEE;
        push_wr(4'h7);
        @(negedge clk);
        rx_valid = 1'b0; host_we = 1'b0;
        hread(4'h7, 8'h01);
        hread(4'h8, 8'hEE);
        cond(2);

        // Reset in the middle of a write transaction
        cond(0);
        rx(8'h0A, 1'b0, 4'h0);
        rx(8'h33, 1'b1, 4'hA);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ptr", {28'h0, ptr}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_tx_data", {24'h0, tx_data}, 32'hff);
        chk("mid_rst_wr_evt", {31'h0, reg_wr_evt}, 32'h0);
        chk("mid_rst_host_rdata", {24'h0, host_rdata}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rx(8'h44, 1'b0, 4'h0);
        rx(8'h55, 1'b0, 4'h0);
        treq(1'b0, 8'h00);
        chk("idle_ptr", {28'h0, ptr}, 32'h0);
        hread(4'hA, 8'h00);
        hread(4'h3, 8'h00);
        cond(0);
        treq(1'b1, 8'h00);
        chk("ptr_cur_addr_read", {28'h0, ptr}, 32'h1);
        cond(2);

        repeat (4) @(negedge clk);
        chk("txq_empty", txq.size(), 32'h0);
        chk("wq_empty", wq.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
